// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared state encoding and width helper for the FIR sequencer
package fir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        BUSY,
        CAPT
    } state_t;

    // Bits needed to index n distinct values; never narrower than one bit
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_table.sv
// rtl/fir_coef_table.sv - ORDER x COEF_WIDTH coefficient register file
module fir_coef_table
    import fir_seq_pkg::*;
#(
    parameter int ORDER      = 6,
    parameter int COEF_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [width_for(ORDER)-1:0]  wr_addr,
    input  logic [COEF_WIDTH-1:0]        wr_data,
    input  logic [width_for(ORDER)-1:0]  rd_addr,
    output logic [COEF_WIDTH-1:0]        rd_data
);

    localparam int ADDR_W = width_for(ORDER);
    // One extra bit so ORDER itself is representable when ORDER is a power of two
    localparam logic [ADDR_W:0] ORDER_L = ORDER[ADDR_W:0];

    logic [COEF_WIDTH-1:0] mem [ORDER];
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < ORDER_L);
    assign rd_in_range = ({1'b0, rd_addr} < ORDER_L);

    // Write port: out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - coefficient loader, sample sequencer and result buffer for fir_seq
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int COEF_WIDTH     = 8,
    parameter int DATA_OUT_WIDTH = 18,
    parameter int ORDER          = 6,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coef_wr_en,
    input  logic [width_for(ORDER)-1:0]  coef_wr_addr,
    input  logic [COEF_WIDTH-1:0]        coef_wr_data,
    input  logic                         cfg_go,
    output logic                         cfg_busy,
    output logic                         coef_loaded,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_IN_WIDTH-1:0]     s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_OUT_WIDTH-1:0]    m_data,
    output logic [CNT_WIDTH-1:0]         sample_cnt,
    output logic                         fir_coef_shift_en,
    output logic [COEF_WIDTH-1:0]        fir_coef_in,
    output logic                         fir_run,
    output logic [DATA_IN_WIDTH-1:0]     fir_data_in,
    input  logic [DATA_OUT_WIDTH-1:0]    fir_data_out
);

    localparam int ADDR_W = width_for(ORDER);
    localparam int DCNT_W = width_for(ORDER + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ORDER - 1);
    localparam logic [DCNT_W-1:0] ORDER_CNT = DCNT_W'(ORDER);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    state_t              state;
    logic [ADDR_W-1:0]   load_idx;
    logic [DCNT_W-1:0]   dcnt;
    logic                go_pend;
    logic                ready_q;
    logic [ADDR_W-1:0]   tbl_rd_addr;
    logic [COEF_WIDTH-1:0] tbl_rd_data;
    logic                tbl_wr_en;
    logic                buf_free;

    // A simultaneous cfg_go must never see a sample handshake, so it gates ready directly
    assign s_ready   = ready_q && !cfg_go;
    assign buf_free  = !m_valid || m_ready;
    assign tbl_wr_en = coef_wr_en && (state != LOAD);

    // Table is read one entry ahead of the shift so fir_coef_in can be registered
    always_comb begin
        tbl_rd_addr = '0;
        if (state == LOAD) begin
            tbl_rd_addr = load_idx + 1'b1;
        end
    end

    fir_coef_table #(
        .ORDER      (ORDER),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tbl_wr_en),
        .wr_addr (coef_wr_addr),
        .wr_data (coef_wr_data),
        .rd_addr (tbl_rd_addr),
        .rd_data (tbl_rd_data)
    );

    // Sequencer FSM with registered FIR-side controls and the one-entry result buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            load_idx          <= '0;
            dcnt              <= '0;
            go_pend           <= 1'b0;
            ready_q           <= 1'b0;
            cfg_busy          <= 1'b0;
            coef_loaded       <= 1'b0;
            m_valid           <= 1'b0;
            m_data            <= '0;
            sample_cnt        <= '0;
            fir_coef_shift_en <= 1'b0;
            fir_coef_in       <= '0;
            fir_run           <= 1'b0;
            fir_data_in       <= '0;
        end else begin
            fir_run <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_go) begin
                        state             <= LOAD;
                        load_idx          <= '0;
                        cfg_busy          <= 1'b1;
                        fir_coef_shift_en <= 1'b1;
                        fir_coef_in       <= tbl_rd_data;
                    end
                end

                LOAD: begin
                    if (load_idx == LAST_IDX) begin
                        state             <= READY;
                        cfg_busy          <= 1'b0;
                        coef_loaded       <= 1'b1;
                        ready_q           <= 1'b1;
                        fir_coef_shift_en <= 1'b0;
                        fir_coef_in       <= '0;
                    end else begin
                        load_idx    <= load_idx + 1'b1;
                        fir_coef_in <= tbl_rd_data;
                    end
                end

                READY: begin
                    if (cfg_go) begin
                        state             <= LOAD;
                        load_idx          <= '0;
                        ready_q           <= 1'b0;
                        cfg_busy          <= 1'b1;
                        fir_coef_shift_en <= 1'b1;
                        fir_coef_in       <= tbl_rd_data;
                    end else if (s_valid && s_ready) begin
                        state       <= BUSY;
                        ready_q     <= 1'b0;
                        fir_run     <= 1'b1;
                        fir_data_in <= s_data;
                        dcnt        <= ORDER_CNT;
                    end
                end

                BUSY: begin
                    if (cfg_go) begin
                        go_pend <= 1'b1;
                    end
                    dcnt <= dcnt - 1'b1;
                    if (dcnt == DCNT_ONE) begin
                        state <= CAPT;
                    end
                end

                CAPT: begin
                    if (buf_free) begin
                        m_data     <= fir_data_out;
                        m_valid    <= 1'b1;
                        sample_cnt <= sample_cnt + 1'b1;
                        if (cfg_go || go_pend) begin
                            state             <= LOAD;
                            go_pend           <= 1'b0;
                            load_idx          <= '0;
                            cfg_busy          <= 1'b1;
                            fir_coef_shift_en <= 1'b1;
                            fir_coef_in       <= tbl_rd_data;
                        end else begin
                            state   <= READY;
                            ready_q <= 1'b1;
                        end
                    end else if (cfg_go) begin
                        go_pend <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

    localparam int ORDER = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_wr_en;
    logic [2:0]  coef_wr_addr;
    logic [7:0]  coef_wr_data;
    logic        cfg_go;
    logic        cfg_busy;
    logic        coef_loaded;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_data;
    logic [15:0] sample_cnt;
    logic        fir_coef_shift_en;
    logic [7:0]  fir_coef_in;
    logic        fir_run;
    logic [7:0]  fir_data_in;
    logic [17:0] fir_data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0]  shift_q [$];
    logic [7:0]  run_q [$];
    logic [17:0] out_q [$];

    logic [7:0]  kreg [ORDER];
    logic [7:0]  xh [ORDER];
    int          fctr;
    logic [17:0] fres;

    fir_seq_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .coef_wr_en        (coef_wr_en),
        .coef_wr_addr      (coef_wr_addr),
        .coef_wr_data      (coef_wr_data),
        .cfg_go            (cfg_go),
        .cfg_busy          (cfg_busy),
        .coef_loaded       (coef_loaded),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .sample_cnt        (sample_cnt),
        .fir_coef_shift_en (fir_coef_shift_en),
        .fir_coef_in       (fir_coef_in),
        .fir_run           (fir_run),
        .fir_data_in       (fir_data_in),
        .fir_data_out      (fir_data_out)
    );

    always #5 clk = ~clk;

    // Stand-in serial FIR: taps shifted in entry 0 first, result presented ORDER cycles after run
    function automatic int fir_sum(input logic [7:0] s);
        int acc;
        acc = int'(kreg[0]) * int'(s);
        for (int i = 1; i < ORDER; i++) begin
            acc = acc + int'(kreg[i]) * int'(xh[i-1]);
        end
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) begin
                xh[i]   <= '0;
                kreg[i] <= '0;
            end
            fctr         <= 0;
            fres         <= '0;
            fir_data_out <= '0;
        end else begin
            if (fir_coef_shift_en) begin
                for (int i = 0; i < ORDER - 1; i++) begin
                    kreg[i] <= kreg[i+1];
                end
                kreg[ORDER-1] <= fir_coef_in;
            end
            if (fir_run) begin
                fres  <= 18'(fir_sum(fir_data_in));
                xh[0] <= fir_data_in;
                for (int i = 1; i < ORDER; i++) begin
                    xh[i] <= xh[i-1];
                end
                fctr         <= ORDER - 1;
                fir_data_out <= 18'h2AAAA;
            end else if (fctr != 0) begin
                fctr <= fctr - 1;
                if (fctr == 1) begin
                    fir_data_out <= fres;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fir_coef_shift_en) shift_q.push_back(fir_coef_in);
        if (fir_run)           run_q.push_back(fir_data_in);
        if (m_valid && m_ready) out_q.push_back(m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        tick();
        coef_wr_en   = 1'b0;
    endtask

    task automatic pulse_go();
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout: s_ready never rose for sample %0h", v);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int cnt);
        int n;
        n = 0;
        while (out_q.size() < cnt && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (out_q.size() != cnt) begin
            errors++;
            $display("FAIL out_count: got %0d results required %0d", out_q.size(), cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        cfg_go = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s_ready, m_valid, cfg_busy, coef_loaded, fir_coef_shift_en, fir_run} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {s_ready, m_valid, cfg_busy, coef_loaded, fir_coef_shift_en, fir_run});
        end
        checks++;
        if ({m_data, sample_cnt, fir_coef_in, fir_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_data: m_data=%0h sample_cnt=%0d coef_in=%0h data_in=%0h required 0",
                     m_data, sample_cnt, fir_coef_in, fir_data_in);
        end
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h55;
        repeat (3) tick();
        checks++;
        if (s_ready !== 1'b0 || run_q.size() != 0) begin
            errors++;
            $display("FAIL idle_no_ready: s_ready=%b runs=%0d required 0 0", s_ready, run_q.size());
        end
        s_valid = 1'b0;
    endtask

    task automatic test_load();
        int n;
        for (int i = 0; i < ORDER; i++) write_coef(3'(i), 8'(i + 1));
        shift_q.delete();
        pulse_go();
        checks++;
        if (cfg_busy !== 1'b1 || fir_coef_shift_en !== 1'b1) begin
            errors++;
            $display("FAIL load_start: cfg_busy=%b shift_en=%b required 1 1", cfg_busy, fir_coef_shift_en);
        end
        n = 0;
        while (cfg_busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != ORDER) begin
            errors++;
            $display("FAIL load_len: got %0d busy cycles required %0d", n, ORDER);
        end
        checks++;
        if (shift_q.size() != ORDER) begin
            errors++;
            $display("FAIL shift_count: got %0d required %0d", shift_q.size(), ORDER);
        end
        for (int i = 0; i < ORDER; i++) begin
            checks++;
            if (shift_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL shift_val[%0d]: got %0h required %0h", i, shift_q[i], i + 1);
            end
        end
        checks++;
        if (coef_loaded !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: coef_loaded=%b s_ready=%b required 1 1", coef_loaded, s_ready);
        end
    endtask

    task automatic test_single();
        int n;
        m_ready = 1'b1;
        out_q.delete();
        send(8'h10);
        checks++;
        if (fir_run !== 1'b1 || fir_data_in !== 8'h10) begin
            errors++;
            $display("FAIL run_pulse: fir_run=%b data_in=%0h required 1 10", fir_run, fir_data_in);
        end
        tick();
        checks++;
        if (fir_run !== 1'b0) begin
            errors++;
            $display("FAIL run_single: fir_run=%b required 0", fir_run);
        end
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n != ORDER) begin
            errors++;
            $display("FAIL result_latency: got %0d cycles required %0d", n, ORDER);
        end
        checks++;
        if (m_data !== 18'd16 || sample_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_result: m_data=%0d sample_cnt=%0d required 16 1", m_data, sample_cnt);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL buffer_drain: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        int unstable;
        m_ready = 1'b0;
        out_q.delete();
        send(8'd2);
        send(8'd3);
        unstable = 0;
        repeat (20) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== 18'd34) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles required 0 (m_data=%0d)", unstable, m_data);
        end
        checks++;
        if (s_ready !== 1'b0 || out_q.size() != 0) begin
            errors++;
            $display("FAIL capt_stall: s_ready=%b delivered=%0d required 0 0", s_ready, out_q.size());
        end
        m_ready = 1'b1;
        wait_out(2);
        checks++;
        if (out_q[0] !== 18'd34 || out_q[1] !== 18'd55) begin
            errors++;
            $display("FAIL b2b_order: got %0d,%0d required 34,55", out_q[0], out_q[1]);
        end
        checks++;
        if (sample_cnt !== 16'd3) begin
            errors++;
            $display("FAIL b2b_count: sample_cnt=%0d required 3", sample_cnt);
        end
    endtask

    task automatic test_go_in_busy();
        int n;
        int bad;
        m_ready = 1'b1;
        out_q.delete();
        for (int i = 0; i < ORDER; i++) write_coef(3'(i), 8'd1);
        send(8'd4);
        tick();
        shift_q.delete();
        pulse_go();
        wait_out(1);
        checks++;
        if (out_q[0] !== 18'd80) begin
            errors++;
            $display("FAIL old_coef_result: got %0d required 80", out_q[0]);
        end
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        bad = 0;
        foreach (shift_q[i]) if (shift_q[i] !== 8'd1) bad++;
        checks++;
        if (shift_q.size() != ORDER || bad != 0) begin
            errors++;
            $display("FAIL pending_load: shifts=%0d bad=%0d required %0d 0", shift_q.size(), bad, ORDER);
        end
        send(8'd5);
        wait_out(2);
        checks++;
        if (out_q[1] !== 18'd30) begin
            errors++;
            $display("FAIL new_coef_result: got %0d required 30", out_q[1]);
        end
    endtask

    task automatic test_go_priority();
        int n;
        m_ready = 1'b1;
        out_q.delete();
        shift_q.delete();
        run_q.delete();
        cfg_go = 1'b1; s_valid = 1'b1; s_data = 8'd7;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL go_gates_ready: s_ready=%b required 0", s_ready);
        end
        tick();
        cfg_go = 1'b0;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n != ORDER || shift_q.size() != ORDER || run_q.size() != 0) begin
            errors++;
            $display("FAIL go_priority: wait=%0d shifts=%0d runs=%0d required %0d %0d 0",
                     n, shift_q.size(), run_q.size(), ORDER, ORDER);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (fir_run !== 1'b1 || fir_data_in !== 8'd7) begin
            errors++;
            $display("FAIL prio_run: fir_run=%b data_in=%0d required 1 7", fir_run, fir_data_in);
        end
        wait_out(1);
        checks++;
        if (out_q[0] !== 18'd37) begin
            errors++;
            $display("FAIL prio_result: got %0d required 37", out_q[0]);
        end
    endtask

    task automatic test_reset_midload();
        int n;
        int rdy;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({coef_loaded, cfg_busy, fir_coef_shift_en, s_ready, m_valid} !== 5'b0 ||
            fir_coef_in !== 8'd0 || sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midload_reset: flags=%b coef_in=%0h cnt=%0d required 00000 0 0",
                     {coef_loaded, cfg_busy, fir_coef_shift_en, s_ready, m_valid}, fir_coef_in, sample_cnt);
        end
        tick();
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'd9;
        rdy = 0;
        repeat (5) begin
            tick();
            if (s_ready !== 1'b0) rdy++;
        end
        s_valid = 1'b0;
        checks++;
        if (rdy != 0) begin
            errors++;
            $display("FAIL no_ready_after_reset: ready on %0d cycles required 0", rdy);
        end
        write_coef(3'd6, 8'd9);
        write_coef(3'd0, 8'd3);
        shift_q.delete();
        pulse_go();
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (shift_q.size() != ORDER || shift_q[0] !== 8'd3 || shift_q[1] !== 8'd0 || shift_q[5] !== 8'd0) begin
            errors++;
            $display("FAIL reload_table: size=%0d first=%0h second=%0h last=%0h required %0d 3 0 0",
                     shift_q.size(), shift_q[0], shift_q[1], shift_q[5], ORDER);
        end
        checks++;
        if (coef_loaded !== 1'b1) begin
            errors++;
            $display("FAIL reload_flag: coef_loaded=%b required 1", coef_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_single();
        test_back_to_back();
        test_go_in_busy();
        test_go_priority();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
